// File: rtl/pic_sched_pkg.sv
// Shared definitions for the picture-ROM fetch scheduler: FSM states, window
// select codes and a half-open span test used by the region comparators.
package pic_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_FETCH0 = 3'd2,
    S_FETCH1 = 3'd3,
    S_DONE   = 3'd4
  } sched_state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN0     = 2'd1;
  localparam logic [1:0] WIN1     = 2'd2;

  function automatic logic in_span(input int v, input int lo, input int len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/pic_rom_fetch_scheduler_tag_delay_line.sv
// Reset-clearable LAT-stage shift register; aligns the fetch owner tag with
// pixel data leaving the ROM and filter pipeline.
module tag_delay_line #(
  parameter int WIDTH = 2,
  parameter int LAT   = 8
) (
  input  logic             pix_clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [LAT];
  logic [WIDTH-1:0] pipe_d [LAT];

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign dout = pipe_q[LAT-1];

endmodule

// File: rtl/pic_rom_fetch_scheduler.sv
// Arbitrates the single picture-ROM read port between WIN0 (raw) and WIN1
// (filtered), issuing addresses LEAD cycles ahead of the raster.
//
// state    | meaning
// S_IDLE   | no frame armed; waiting for a vs edge with en=1
// S_SCAN   | frame armed, raster outside both fetch regions
// S_FETCH0 | WIN0 owns the ROM port this cycle
// S_FETCH1 | WIN1 owns the ROM port this cycle
// S_DONE   | all WIN1 pixels fetched; waiting for next frame start
module pic_rom_fetch_scheduler
  import pic_sched_pkg::*;
#(
  parameter int X_BITS    = 12,
  parameter int Y_BITS    = 12,
  parameter int ADDR_BITS = 16,
  parameter int PIC_W     = 256,
  parameter int PIC_H     = 256,
  parameter int WIN0_X    = 640,
  parameter int WIN1_X    = 1024,
  parameter int WIN_Y     = 412,
  parameter int LEAD      = 8
) (
  input  logic                 pix_clk,
  input  logic                 rstn,
  input  logic                 vs_in,
  input  logic                 de_in,
  input  logic [X_BITS-1:0]    act_x,
  input  logic [Y_BITS-1:0]    act_y,
  input  logic                 en,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic                 rom_rd_en,
  output logic [1:0]           fetch_win,
  output logic [1:0]           pix_sel,
  output logic                 frame_done
);

  // One extra bit so the counters can hold the saturation value PIC_W*PIC_H.
  localparam int CNT_BITS = ADDR_BITS + 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(PIC_W * PIC_H);

  sched_state_t         state_q, state_d;
  logic                 vs_q;
  logic [CNT_BITS-1:0]  cnt0_q, cnt0_d;
  logic [CNT_BITS-1:0]  cnt1_q, cnt1_d;
  logic [ADDR_BITS-1:0] rom_addr_q, rom_addr_d;
  logic                 rom_rd_en_q, rom_rd_en_d;
  logic [1:0]           fetch_win_q, fetch_win_d;
  logic                 frame_done_q, frame_done_d;

  logic                 frame_start;
  logic                 in_r0, in_r1;
  logic                 run;
  logic                 fetch0, fetch1;
  logic [CNT_BITS-1:0]  base0, base1;

  always_comb begin
    frame_start = vs_in & ~vs_q;
    in_r0 = de_in && in_span(int'(act_y), WIN_Y, PIC_H)
                  && in_span(int'(act_x), WIN0_X - LEAD, PIC_W);
    in_r1 = de_in && in_span(int'(act_y), WIN_Y, PIC_H)
                  && in_span(int'(act_x), WIN1_X - LEAD, PIC_W);

    // A frame start with en=1 already fetches in the same cycle from cleared counters.
    run   = frame_start ? en
                        : (state_q == S_SCAN || state_q == S_FETCH0 || state_q == S_FETCH1);
    base0 = frame_start ? '0 : cnt0_q;
    base1 = frame_start ? '0 : cnt1_q;

    fetch0 = run && in_r0;
    fetch1 = run && in_r1 && !in_r0;

    cnt0_d = base0;
    if (fetch0 && base0 != CNT_MAX) cnt0_d = base0 + CNT_BITS'(1);
    // WIN1 keeps counting while WIN0 holds the port so its geometry stays intact.
    cnt1_d = base1;
    if (run && in_r1 && base1 != CNT_MAX) cnt1_d = base1 + CNT_BITS'(1);

    rom_rd_en_d = fetch0 || fetch1;
    fetch_win_d = fetch0 ? WIN0 : (fetch1 ? WIN1 : WIN_NONE);
    rom_addr_d  = fetch0 ? base0[ADDR_BITS-1:0]
                         : (fetch1 ? base1[ADDR_BITS-1:0] : '0);

    if (run) begin
      if (cnt1_d == CNT_MAX) state_d = S_DONE;
      else if (in_r0)        state_d = S_FETCH0;
      else if (in_r1)        state_d = S_FETCH1;
      else                   state_d = S_SCAN;
    end else if (frame_start) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_q;
    end

    frame_done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      vs_q         <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      rom_addr_q   <= '0;
      rom_rd_en_q  <= 1'b0;
      fetch_win_q  <= WIN_NONE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= vs_in;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      rom_addr_q   <= rom_addr_d;
      rom_rd_en_q  <= rom_rd_en_d;
      fetch_win_q  <= fetch_win_d;
      frame_done_q <= frame_done_d;
    end
  end

  tag_delay_line #(
    .WIDTH(2),
    .LAT  (LEAD)
  ) u_tag_delay (
    .pix_clk(pix_clk),
    .rstn   (rstn),
    .din    (fetch_win_q),
    .dout   (pix_sel)
  );

  assign rom_addr   = rom_addr_q;
  assign rom_rd_en  = rom_rd_en_q;
  assign fetch_win  = fetch_win_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pic_rom_fetch_scheduler.sv
// Randomized self-checking bench for pic_rom_fetch_scheduler; a behavioural
// frame model predicts every output, a second instance covers overlapping windows.
module tb_pic_rom_fetch_scheduler;

  localparam int WIN_Y   = 412;
  localparam int PIC_W   = 256;
  localparam int PIC_H   = 256;
  localparam int LEAD    = 8;
  localparam int R0_LO   = 640 - LEAD;
  localparam int R1_LO   = 1024 - LEAD;
  localparam int R1B_LO  = 800 - LEAD;
  localparam int NPIX    = PIC_W * PIC_H;

  logic        pix_clk = 1'b0;
  logic        rstn    = 1'b0;
  logic        vs_in   = 1'b0;
  logic        de_in   = 1'b0;
  logic [11:0] act_x   = '0;
  logic [11:0] act_y   = '0;
  logic        en      = 1'b0;

  logic [15:0] rom_addr;
  logic        rom_rd_en;
  logic [1:0]  fetch_win;
  logic [1:0]  pix_sel;
  logic        frame_done;

  logic [15:0] rom_addr_b;
  logic        rom_rd_en_b;
  logic [1:0]  fetch_win_b;
  logic [1:0]  pix_sel_b;
  logic        frame_done_b;

  int checks = 0;
  int errors = 0;

  always #5 pix_clk = ~pix_clk;

  pic_rom_fetch_scheduler dut (
    .pix_clk(pix_clk), .rstn(rstn), .vs_in(vs_in), .de_in(de_in),
    .act_x(act_x), .act_y(act_y), .en(en),
    .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .fetch_win(fetch_win),
    .pix_sel(pix_sel), .frame_done(frame_done)
  );

  pic_rom_fetch_scheduler #(.WIN1_X(800)) dut_ovl (
    .pix_clk(pix_clk), .rstn(rstn), .vs_in(vs_in), .de_in(de_in),
    .act_x(act_x), .act_y(act_y), .en(en),
    .rom_addr(rom_addr_b), .rom_rd_en(rom_rd_en_b), .fetch_win(fetch_win_b),
    .pix_sel(pix_sel_b), .frame_done(frame_done_b)
  );

  // Behavioural model of the default-geometry instance: a frame is "armed" from
  // a vs rising edge with en=1 until all WIN1 pixels are counted.
  int          m_c0, m_c1;
  bit          m_on, m_vs_prev;
  int          m_hist [LEAD];
  logic [15:0] exp_addr;
  logic        exp_rd, exp_done;
  logic [1:0]  exp_win, exp_pix;

  initial begin
    forever begin
      @(posedge pix_clk or negedge rstn);
      if (!rstn) begin
        m_c0 = 0; m_c1 = 0; m_on = 0; m_vs_prev = 0;
        for (int i = 0; i < LEAD; i++) m_hist[i] = 0;
        exp_addr = '0; exp_rd = 0; exp_win = '0; exp_pix = '0; exp_done = 0;
      end else begin
        bit fs, in0, in1, in_y;
        int win;
        fs = vs_in && !m_vs_prev;
        m_vs_prev = vs_in;
        if (fs) begin m_c0 = 0; m_c1 = 0; m_on = en; end
        in_y = act_y >= WIN_Y && act_y < WIN_Y + PIC_H;
        in0 = de_in && in_y && act_x >= R0_LO && act_x < R0_LO + PIC_W;
        in1 = de_in && in_y && act_x >= R1_LO && act_x < R1_LO + PIC_W;
        win = 0;
        exp_addr = '0;
        if (m_on && in0)      begin win = 1; exp_addr = m_c0[15:0]; end
        else if (m_on && in1) begin win = 2; exp_addr = m_c1[15:0]; end
        exp_win = win[1:0];
        exp_rd  = (win != 0);
        exp_pix = m_hist[LEAD-1][1:0];
        for (int i = LEAD-1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = win;
        if (m_on && in0 && m_c0 < NPIX) m_c0++;
        if (m_on && in1 && m_c1 < NPIX) m_c1++;
        exp_done = 0;
        if (m_on && m_c1 == NPIX) begin m_on = 0; exp_done = 1; end
      end
    end
  end

  task automatic step(input logic vs, input logic de, input int x, input int y);
    vs_in = vs;
    de_in = de;
    act_x = x[11:0];
    act_y = y[11:0];
    @(posedge pix_clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(posedge pix_clk);
    #1;
    checks++;
    if ({rom_addr, rom_rd_en, fetch_win, pix_sel, frame_done} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0d rd=%0b win=%0d sel=%0d done=%0b, want all 0",
               rom_addr, rom_rd_en, fetch_win, pix_sel, frame_done);
    end
    rstn = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if (rom_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_rd: got %0b want 0", rom_rd_en);
    end
  endtask

  task automatic test_first_fetch;
    en = 1'b1;
    step(1, 1, R0_LO, WIN_Y);
    checks++;
    if (rom_addr !== 16'd0 || rom_rd_en !== 1'b1 || fetch_win !== 2'd1) begin
      errors++;
      $display("FAIL first_fetch: got addr=%0d rd=%0b win=%0d want addr=0 rd=1 win=1",
               rom_addr, rom_rd_en, fetch_win);
    end
    for (int x = R0_LO + 1; x <= R0_LO + LEAD; x++) begin
      step(0, 1, x, WIN_Y);
      if (x == R0_LO + LEAD - 1) begin
        checks++;
        if (pix_sel !== 2'd0) begin
          errors++;
          $display("FAIL pix_sel_early: got %0d want 0 at x=%0d", pix_sel, x);
        end
      end
      checks++;
      if ({rom_addr, rom_rd_en, fetch_win, pix_sel, frame_done} !==
          {exp_addr, exp_rd, exp_win, exp_pix, exp_done}) begin
        errors++;
        $display("FAIL first_line_model x=%0d: got %h %b %0d %0d %b want %h %b %0d %0d %b", x,
                 rom_addr, rom_rd_en, fetch_win, pix_sel, frame_done,
                 exp_addr, exp_rd, exp_win, exp_pix, exp_done);
      end
    end
    checks++;
    if (pix_sel !== 2'd1) begin
      errors++;
      $display("FAIL pix_sel_lead: got %0d want 1 after %0d cycles", pix_sel, LEAD);
    end
  endtask

  task automatic test_win1_line;
    for (int x = R0_LO + LEAD + 1; x < R1_LO + PIC_W; x++) begin
      step(0, 1, x, WIN_Y);
      checks++;
      if ({rom_addr, rom_rd_en, fetch_win, pix_sel} !== {exp_addr, exp_rd, exp_win, exp_pix}) begin
        errors++;
        $display("FAIL line412_model x=%0d: got %h %b %0d %0d want %h %b %0d %0d", x,
                 rom_addr, rom_rd_en, fetch_win, pix_sel, exp_addr, exp_rd, exp_win, exp_pix);
      end
      if (x >= R1_LO) begin
        checks++;
        if (rom_addr !== 16'(x - R1_LO) || fetch_win !== 2'd2) begin
          errors++;
          $display("FAIL win1_addr x=%0d: got addr=%0d win=%0d want addr=%0d win=2",
                   x, rom_addr, fetch_win, x - R1_LO);
        end
      end
    end
    step(0, 0, 0, WIN_Y + 1);
    step(0, 1, R1_LO, WIN_Y + 1);
    checks++;
    if (rom_addr !== 16'd256 || fetch_win !== 2'd2) begin
      errors++;
      $display("FAIL line413_addr: got addr=%0d win=%0d want addr=256 win=2", rom_addr, fetch_win);
    end
  endtask

  task automatic test_overlap;
    step(0, 0, 0, WIN_Y);
    step(1, 0, 0, WIN_Y);
    for (int x = R0_LO; x < R1B_LO + PIC_W; x++) begin
      logic [1:0]  w;
      logic [15:0] a;
      step(0, 1, x, WIN_Y);
      w = (x < R0_LO + PIC_W) ? 2'd1 : 2'd2;
      a = (x < R0_LO + PIC_W) ? 16'(x - R0_LO) : 16'(x - R1B_LO);
      checks++;
      if (fetch_win_b !== w || rom_addr_b !== a || rom_rd_en_b !== 1'b1) begin
        errors++;
        $display("FAIL overlap x=%0d: got addr=%0d win=%0d rd=%0b want addr=%0d win=%0d rd=1",
                 x, rom_addr_b, fetch_win_b, rom_rd_en_b, a, w);
      end
    end
    checks++;
    if ({rom_addr, fetch_win} !== {exp_addr, exp_win}) begin
      errors++;
      $display("FAIL overlap_main_model: got %h %0d want %h %0d", rom_addr, fetch_win, exp_addr, exp_win);
    end
  endtask

  task automatic test_random_raster;
    step(0, 0, 0, WIN_Y);
    step(1, 0, 0, WIN_Y);
    for (int y = WIN_Y; y < WIN_Y + 3; y++) begin
      for (int x = 620; x < 1280; x++) begin
        en = 1'($urandom_range(1));
        step(0, ($urandom_range(3) != 0), x, y);
        checks++;
        if ({rom_addr, rom_rd_en, fetch_win, pix_sel, frame_done} !==
            {exp_addr, exp_rd, exp_win, exp_pix, exp_done}) begin
          errors++;
          $display("FAIL random_raster y=%0d x=%0d: got %h %b %0d %0d %b want %h %b %0d %0d %b", y, x,
                   rom_addr, rom_rd_en, fetch_win, pix_sel, frame_done,
                   exp_addr, exp_rd, exp_win, exp_pix, exp_done);
        end
      end
      step(0, 0, 0, y);
    end
    en = 1'b1;
  endtask

  task automatic test_full_frame;
    int done_cnt;
    logic [15:0] done_addr;
    done_cnt = 0;
    done_addr = '0;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int y = WIN_Y; y < WIN_Y + PIC_H; y++) begin
      for (int x = R1_LO; x < R1_LO + PIC_W; x++) begin
        step(0, 1, x, y);
        if (frame_done === 1'b1) begin
          done_cnt++;
          done_addr = rom_addr;
        end
        checks++;
        if ({rom_addr, rom_rd_en, fetch_win, pix_sel, frame_done} !==
            {exp_addr, exp_rd, exp_win, exp_pix, exp_done}) begin
          errors++;
          $display("FAIL full_frame y=%0d x=%0d: got %h %b %0d %0d %b want %h %b %0d %0d %b", y, x,
                   rom_addr, rom_rd_en, fetch_win, pix_sel, frame_done,
                   exp_addr, exp_rd, exp_win, exp_pix, exp_done);
        end
      end
      step(0, 0, 0, y);
    end
    checks++;
    if (done_cnt !== 1 || done_addr !== 16'd65535) begin
      errors++;
      $display("FAIL frame_done: got %0d pulses at addr %0d want 1 pulse at addr 65535", done_cnt, done_addr);
    end
    for (int x = R0_LO; x < R0_LO + 40; x++) begin
      step(0, 1, x, WIN_Y);
      checks++;
      if (rom_rd_en !== 1'b0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL after_done x=%0d: got rd=%0b done=%0b want 0 0", x, rom_rd_en, frame_done);
      end
    end
  endtask

  task automatic test_reset_mid_line;
    step(0, 0, 0, WIN_Y);
    step(1, 0, 0, WIN_Y);
    for (int x = R0_LO; x < R0_LO + 30; x++) step(0, 1, x, WIN_Y);
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({rom_addr, rom_rd_en, fetch_win, pix_sel, frame_done} !== 22'd0) begin
      errors++;
      $display("FAIL async_reset: got addr=%0d rd=%0b win=%0d sel=%0d done=%0b want all 0",
               rom_addr, rom_rd_en, fetch_win, pix_sel, frame_done);
    end
    @(posedge pix_clk);
    #1 rstn = 1'b1;
    for (int x = R0_LO + 31; x < R1_LO + PIC_W; x++) begin
      step(0, 1, x, WIN_Y);
      checks++;
      if (rom_rd_en !== 1'b0 || rom_rd_en !== exp_rd) begin
        errors++;
        $display("FAIL post_reset_idle x=%0d: got rd=%0b want 0", x, rom_rd_en);
      end
    end
    step(1, 1, R0_LO, WIN_Y);
    checks++;
    if (rom_rd_en !== 1'b1 || rom_addr !== 16'd0 || fetch_win !== 2'd1) begin
      errors++;
      $display("FAIL resume_after_vs: got rd=%0b addr=%0d win=%0d want rd=1 addr=0 win=1",
               rom_rd_en, rom_addr, fetch_win);
    end
  endtask

  task automatic test_en_gating;
    for (int i = 0; i < LEAD + 2; i++) step(0, 0, 0, WIN_Y);
    en = 1'b0;
    step(1, 0, 0, WIN_Y);
    for (int y = WIN_Y; y < WIN_Y + 2; y++) begin
      for (int x = R0_LO; x < R1_LO + PIC_W; x++) begin
        en = 1'($urandom_range(1));
        step(0, 1, x, y);
        checks++;
        if (rom_rd_en !== 1'b0 || pix_sel !== 2'd0 || fetch_win !== exp_win) begin
          errors++;
          $display("FAIL en_gated y=%0d x=%0d: got rd=%0b sel=%0d win=%0d want rd=0 sel=0 win=0",
                   y, x, rom_rd_en, pix_sel, fetch_win);
        end
      end
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_win1_line();
    test_overlap();
    test_random_raster();
    test_full_frame();
    test_reset_mid_line();
    test_en_gating();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
